// File: rtl/adder_phase_ctrl.sv
// Operand holder, 8-phase power-clock generator and result capture for the adiabatic prefix adder.
// Latency: accept to out_valid 9 cycles; in_ready drops while busy or while a result waits.
module adder_phase_ctrl #(
  parameter int WIDTH    = 16,
  parameter int NPHASE   = 8,
  parameter int HOLD_CYC = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_a,
  input  logic [WIDTH-1:0]  in_b,
  input  logic              in_cin,
  output logic [WIDTH-1:0]  add_a,
  output logic [WIDTH-1:0]  add_b,
  output logic              add_cin,
  output logic [NPHASE-1:0] clkpos,
  output logic [NPHASE-1:0] clkneg,
  input  logic [WIDTH-1:0]  add_sum,
  input  logic              add_cout,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_sum,
  output logic              out_cout,
  output logic              busy
);

  localparam int LAST = NPHASE - 1 + HOLD_CYC;
  localparam int CW   = $clog2(LAST + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic [NPHASE-1:0] phase_nxt;
  logic              accept, capture, ov_nxt;

  assign accept  = in_valid && in_ready;
  assign capture = (state == RUN) && (cnt == CW'(NPHASE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (cnt == CW'(LAST)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Phases are decoded from the next count so the phase flops switch cleanly on the edge.
  always_comb begin
    cnt_nxt = '0;
    if (state_nxt == RUN)
      cnt_nxt = (state == IDLE) ? CW'(1) : cnt + CW'(1);
    phase_nxt = '0;
    for (int i = 0; i < NPHASE; i++)
      phase_nxt[i] = (cnt_nxt >= CW'(i + 1)) && (cnt_nxt <= CW'(i + HOLD_CYC));
    ov_nxt = out_valid;
    if (capture)                     ov_nxt = 1'b1;
    else if (out_valid && out_ready) ov_nxt = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      clkpos    <= '0;
      clkneg    <= '1;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
      add_a     <= '0;
      add_b     <= '0;
      add_cin   <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
    end else begin
      cnt       <= cnt_nxt;
      clkpos    <= phase_nxt;
      clkneg    <= ~phase_nxt;
      busy      <= (state_nxt == RUN);
      in_ready  <= (state_nxt == IDLE) && !ov_nxt;
      out_valid <= ov_nxt;
      if (accept) begin
        add_a   <= in_a;
        add_b   <= in_b;
        add_cin <= in_cin;
      end
      // Phases NPHASE-2 and NPHASE-1 are both powered here, so the adder output is settled.
      if (capture) begin
        out_sum  <= add_sum;
        out_cout <= add_cout;
      end
    end
  end

endmodule

// File: tb/tb_adder_phase_ctrl.sv
// Bench for adder_phase_ctrl: behavioural adder that only drives a valid sum while phases 6 and 7 overlap.
module tb_adder_phase_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_a = '0, in_b = '0;
  logic        in_cin = 1'b0;
  logic [15:0] add_a, add_b;
  logic        add_cin;
  logic [7:0]  clkpos, clkneg;
  logic [15:0] add_sum;
  logic        add_cout;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_sum;
  logic        out_cout;
  logic        busy;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc_cnt = 0;
  int          last_accept = 0;
  logic [16:0] sb[$];

  adder_phase_ctrl #(.WIDTH(16), .NPHASE(8), .HOLD_CYC(3)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .clkpos(clkpos), .clkneg(clkneg),
    .add_sum(add_sum), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Garbage outside the evaluation window exposes a mistimed capture.
  always_comb begin
    if (clkpos[6] && clkpos[7])
      {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {16'd0, add_cin};
    else
      {add_cout, add_sum} = {1'b0, 16'hDEAD};
  end

  // Returns at the negedge of cycle 1 after the accepting edge.
  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic cin);
    int t = 0;
    @(negedge clk);
    while (!in_ready && t < 60) begin
      @(negedge clk);
      t++;
    end
    n_tests++;
    if (t >= 60) begin
      n_fail++;
      $display("FAIL issue_timeout: in_ready=%b, required 1 within 60 cycles", in_ready);
    end
    in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1;
    last_accept = cyc_cnt;
    sb.push_back({1'b0, a} + {1'b0, b} + {16'd0, cin});
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic take_result(input string name);
    int t = 0;
    logic [16:0] exp;
    while (!out_valid && t < 60) begin
      @(negedge clk);
      t++;
    end
    n_tests++;
    if (t >= 60) begin
      n_fail++;
      $display("FAIL %s_timeout: out_valid=%b, required 1 within 60 cycles", name, out_valid);
    end
    n_tests++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL %s_sb_empty: result present, no expectation queued", name);
    end else begin
      exp = sb.pop_front();
      if ({out_cout, out_sum} !== exp) begin
        n_fail++;
        $display("FAIL %s: cout/sum=%b/%h, required %b/%h", name, out_cout, out_sum, exp[16], exp[15:0]);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_tests++;
    if (clkpos !== 8'h00 || clkneg !== 8'hFF) begin
      n_fail++;
      $display("FAIL reset_phases: clkpos=%h clkneg=%h, required 00/ff", clkpos, clkneg);
    end
    n_tests++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: out_valid=%b busy=%b, required 0/0", out_valid, busy);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if (in_ready !== 1'b1 || add_a !== 16'h0 || out_sum !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_release: in_ready=%b add_a=%h out_sum=%h, required 1/0000/0000",
               in_ready, add_a, out_sum);
    end
  endtask

  task automatic test_basic();
    int cyc = 1;
    issue(16'h1234, 16'h4321, 1'b0);
    while (!out_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    n_tests++;
    if (cyc != 9) begin
      n_fail++;
      $display("FAIL basic_latency: out_valid in cycle %0d, required 9", cyc);
    end
    take_result("basic_sum");
  endtask

  task automatic test_carry();
    issue(16'hFFFF, 16'h0001, 1'b0);
    take_result("carry_wrap");
    issue(16'hFFFF, 16'h0000, 1'b1);
    take_result("carry_cin");
  endtask

  task automatic test_phases();
    logic [7:0] exp;
    issue(16'h00FF, 16'h0F00, 1'b1);
    for (int k = 1; k <= 12; k++) begin
      exp = '0;
      for (int i = 0; i < 8; i++) exp[i] = (k >= i + 1) && (k <= i + 3);
      n_tests++;
      if (clkpos !== exp || clkneg !== ~exp) begin
        n_fail++;
        $display("FAIL phase_c%0d: clkpos=%h clkneg=%h, required %h/%h", k, clkpos, clkneg, exp, ~exp);
      end
      n_tests++;
      if (busy !== (k <= 10)) begin
        n_fail++;
        $display("FAIL busy_c%0d: busy=%b, required %b", k, busy, (k <= 10));
      end
      @(negedge clk);
    end
    take_result("phase_sum");
  endtask

  task automatic test_backpressure();
    int t = 0;
    logic [16:0] exp;
    issue(16'hA5A5, 16'h0F0F, 1'b0);
    while (!out_valid && t < 40) begin
      @(negedge clk);
      t++;
    end
    exp = {1'b0, 16'hA5A5} + {1'b0, 16'h0F0F};
    in_a = 16'h1111; in_b = 16'h2222; in_cin = 1'b1; in_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      n_tests++;
      if ({out_cout, out_sum} !== exp || out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL bp_hold_%0d: valid=%b sum=%h, required 1/%h", k, out_valid, out_sum, exp[15:0]);
      end
      n_tests++;
      if (in_ready !== 1'b0 || add_a !== 16'hA5A5) begin
        n_fail++;
        $display("FAIL bp_block_%0d: in_ready=%b add_a=%h, required 0/a5a5", k, in_ready, add_a);
      end
    end
    take_result("bp_sum");
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_release: in_ready=%b out_valid=%b, required 1/0", in_ready, out_valid);
    end
    sb.push_back({1'b0, 16'h1111} + {1'b0, 16'h2222} + 17'd1);
    @(negedge clk);
    in_valid = 1'b0;
    n_tests++;
    if (busy !== 1'b1 || add_a !== 16'h1111) begin
      n_fail++;
      $display("FAIL bp_next_accept: busy=%b add_a=%h, required 1/1111", busy, add_a);
    end
    take_result("bp_next_sum");
  endtask

  task automatic test_reset_mid();
    issue(16'h7777, 16'h1111, 1'b0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    void'(sb.pop_back());
    n_tests++;
    if (clkpos !== 8'h00 || clkneg !== 8'hFF || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_phases: clkpos=%h clkneg=%h busy=%b, required 00/ff/0", clkpos, clkneg, busy);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    begin
      int seen = 0;
      for (int k = 0; k < 15; k++) begin
        @(negedge clk);
        if (out_valid) seen++;
      end
      n_tests++;
      if (seen != 0) begin
        n_fail++;
        $display("FAIL midreset_no_valid: out_valid high %0d cycles, required 0", seen);
      end
    end
    issue(16'h0102, 16'h0304, 1'b1);
    take_result("midreset_fresh");
  endtask

  task automatic test_back_to_back();
    int prev;
    logic [15:0] a, b;
    issue(16'h8000, 16'h8000, 1'b1);
    take_result("b2b_0");
    for (int k = 1; k <= 4; k++) begin
      prev = last_accept;
      a = 16'($urandom);
      b = 16'($urandom);
      issue(a, b, 1'($urandom_range(0, 1)));
      n_tests++;
      if (last_accept - prev != 11) begin
        n_fail++;
        $display("FAIL b2b_interval_%0d: %0d cycles, required 11", k, last_accept - prev);
      end
      take_result("b2b_sum");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_phases();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
